// File: rtl/pdr_rule_matcher_pkg.sv
// pdr_rule_matcher_pkg: parser PHS layout, PDR rule entry and matcher FSM states
package pdr_rule_matcher_pkg;
  typedef struct packed {
    logic [31:0] ipv4_src_addr;
    logic [31:0] ipv4_dst_addr;
    logic [15:0] l4_src_port;
    logic [15:0] l4_dst_port;
    logic [7:0]  ip_proto;
    logic [7:0]  tos;
    logic [5:0]  qfi;
    logic [1:0]  src_iface;
  } PHS_Struct;
  typedef struct packed {
    logic      en;
    PHS_Struct mask;
    PHS_Struct value;
  } PdrRule;
  typedef enum logic [1:0] {PDR_IDLE, PDR_SCAN, PDR_DONE} PDR_STATES;
endpackage

// File: rtl/pdr_rule_matcher_table.sv
// pdr_rule_table: rule entry storage with reset-cleared enables and one async read port
module pdr_rule_table
  import pdr_rule_matcher_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  PdrRule           cfg_rule,
  input  logic [IDX_W-1:0] rd_idx,
  output PdrRule           rd_rule
);
  logic [NUM_RULES-1:0] en_q;
  PHS_Struct            mask_q  [NUM_RULES];
  PHS_Struct            value_q [NUM_RULES];
  // enables are the only state reset needs to clear: a disabled entry never matches
  always_ff @(posedge clk) begin
    if (!rst_n) en_q <= '0;
    else if (cfg_we) en_q[cfg_idx] <= cfg_rule.en;
  end
  // mask/value payload carries no reset
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      mask_q[cfg_idx]  <= cfg_rule.mask;
      value_q[cfg_idx] <= cfg_rule.value;
    end
  end
  assign rd_rule = {en_q[rd_idx], mask_q[rd_idx], value_q[rd_idx]};
endmodule

// File: rtl/pdr_rule_matcher.sv
// pdr_rule_matcher: sequential first-match scan of PHS against the PDR rule table
module pdr_rule_matcher
  import pdr_rule_matcher_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int IDX_W     = $clog2(NUM_RULES),
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phs_valid,
  output logic             phs_ready,
  input  PHS_Struct        phs_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  PdrRule           cfg_rule,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output PHS_Struct        res_phs,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  PDR_STATES        state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d, res_idx_q, res_idx_d;
  PHS_Struct        phs_q, phs_d;
  logic             res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  PdrRule           rule;
  logic             match;

  pdr_rule_table #(.NUM_RULES(NUM_RULES), .IDX_W(IDX_W)) u_table (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_rule(cfg_rule), .rd_idx(scan_idx_q), .rd_rule(rule)
  );

  assign match      = rule.en && (((phs_q ^ rule.value) & rule.mask) == '0);
  assign phs_ready  = (state_q == PDR_IDLE);
  assign res_valid  = res_valid_q;
  assign res_hit    = res_hit_q;
  assign res_idx    = res_idx_q;
  assign res_phs    = phs_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // next-state: accept in IDLE, one rule per cycle in SCAN, hold result in DONE
  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    phs_d       = phs_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_idx_d   = res_idx_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    case (state_q)
      PDR_IDLE: if (phs_valid) begin
        phs_d      = phs_data;
        scan_idx_d = '0;
        state_d    = PDR_SCAN;
      end
      PDR_SCAN: if (match || scan_idx_q == IDX_W'(NUM_RULES - 1)) begin
        res_hit_d   = match;
        res_idx_d   = match ? scan_idx_q : '0;
        res_valid_d = 1'b1;
        state_d     = PDR_DONE;
      end else begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      PDR_DONE: if (res_ready) begin
        res_valid_d = 1'b0;
        hit_d       = res_hit_q ? hit_q + CNT_W'(1) : hit_q;
        miss_d      = res_hit_q ? miss_q : miss_q + CNT_W'(1);
        state_d     = PDR_IDLE;
      end
      default: state_d = PDR_IDLE;
    endcase
  end

  // all matcher state registers; reset drops any in-flight packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PDR_IDLE;
      scan_idx_q  <= '0;
      phs_q       <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      phs_q       <= phs_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end
endmodule

// File: tb/tb_pdr_rule_matcher.sv
// tb_pdr_rule_matcher: directed checks of scan latency, priority, hold, live config and reset
module tb_pdr_rule_matcher;
  import pdr_rule_matcher_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic        phs_valid = 0, phs_ready, cfg_we = 0, res_valid, res_ready = 0, res_hit;
  logic [2:0]  cfg_idx = 0, res_idx;
  PHS_Struct   phs_data = '0, res_phs, p1, p2, p3;
  PdrRule      cfg_rule = '0, r;
  logic [31:0] hit_count, miss_count;
  int          n_chk = 0, n_fail = 0, lat;

  pdr_rule_matcher dut (
    .clk(clk), .rst_n(rst_n), .phs_valid(phs_valid), .phs_ready(phs_ready),
    .phs_data(phs_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rule(cfg_rule),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_idx(res_idx),
    .res_phs(res_phs), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input PdrRule rule);
    cfg_we = 1; cfg_idx = idx; cfg_rule = rule;
    tick();
    cfg_we = 0;
  endtask

  task automatic wait_res();
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input PHS_Struct p);
    phs_data = p; phs_valid = 1;
    tick();
    phs_valid = 0;
    lat = 1;
    wait_res();
  endtask

  task automatic release_res();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    p1 = '0; p1.ipv4_dst_addr = 32'h0A000001;
    p2 = '0; p2.ipv4_src_addr = 32'hC0A80001; p2.ipv4_dst_addr = 32'h0A000002; p2.l4_dst_port = 16'd2152;
    p3 = '0; p3.ipv4_src_addr = 32'h01020304; p3.ipv4_dst_addr = 32'h0B000000; p3.ip_proto = 8'd17;
    tick(); tick();
    rst_n = 1;
    chk("rst_valid", 128'(res_valid), 128'(0));
    chk("rst_hit", 128'(res_hit), 128'(0));
    chk("rst_idx", 128'(res_idx), 128'(0));
    chk("rst_phs", 128'(res_phs), 128'(0));
    chk("rst_hits", 128'(hit_count), 128'(0));
    chk("rst_miss", 128'(miss_count), 128'(0));
    chk("rst_ready", 128'(phs_ready), 128'(1));
    // empty table: full scan then miss
    send(p1);
    chk("miss_lat", 128'(lat), 128'(9));
    chk("miss_hit", 128'(res_hit), 128'(0));
    chk("miss_idx", 128'(res_idx), 128'(0));
    chk("miss_ready", 128'(phs_ready), 128'(0));
    release_res();
    chk("miss_cnt", 128'(miss_count), 128'(1));
    chk("miss_hcnt", 128'(hit_count), 128'(0));
    chk("idle_ready", 128'(phs_ready), 128'(1));
    // rule 3 on dst address
    r = '0; r.en = 1; r.mask.ipv4_dst_addr = '1; r.value.ipv4_dst_addr = 32'h0A000001;
    wr(3, r);
    p1.ipv4_src_addr = 32'hC0A80001; p1.l4_src_port = 16'h1234;
    send(p1);
    chk("r3_lat", 128'(lat), 128'(5));
    chk("r3_hit", 128'(res_hit), 128'(1));
    chk("r3_idx", 128'(res_idx), 128'(3));
    chk("r3_phs", 128'(res_phs), 128'(p1));
    release_res();
    chk("r3_hcnt", 128'(hit_count), 128'(1));
    // rule 2 on src address, rule 5 wildcard: lowest index wins
    r = '0; r.en = 1; r.mask.ipv4_src_addr = '1; r.value.ipv4_src_addr = 32'hC0A80001;
    wr(2, r);
    r = '0; r.en = 1;
    wr(5, r);
    send(p2);
    chk("prio_lat", 128'(lat), 128'(4));
    chk("prio_idx", 128'(res_idx), 128'(2));
    release_res();
    r = '0;
    wr(2, r);
    send(p2);
    chk("wild_lat", 128'(lat), 128'(7));
    chk("wild_hit", 128'(res_hit), 128'(1));
    chk("wild_idx", 128'(res_idx), 128'(5));
    chk("wild_phs", 128'(res_phs), 128'(p2));
    // downstream stall holds everything
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 128'(res_valid), 128'(1));
      chk("hold_idx", 128'(res_idx), 128'(5));
      chk("hold_phs", 128'(res_phs), 128'(p2));
      chk("hold_ready", 128'(phs_ready), 128'(0));
      chk("hold_hcnt", 128'(hit_count), 128'(2));
    end
    release_res();
    chk("pulse_ready", 128'(phs_ready), 128'(1));
    chk("pulse_valid", 128'(res_valid), 128'(0));
    chk("pulse_hcnt", 128'(hit_count), 128'(3));
    r = '0;
    wr(5, r);
    // live config: rule 1 written while compared (too late), rule 6 ahead of scan
    phs_data = p3; phs_valid = 1;
    tick();
    phs_valid = 0;
    tick();
    r = '0; r.en = 1;
    cfg_we = 1; cfg_idx = 1; cfg_rule = r;
    tick();
    r = '0; r.en = 1; r.mask = '1; r.value = p3;
    cfg_idx = 6; cfg_rule = r;
    tick();
    cfg_we = 0;
    lat = 4;
    wait_res();
    chk("live_lat", 128'(lat), 128'(8));
    chk("live_hit", 128'(res_hit), 128'(1));
    chk("live_idx", 128'(res_idx), 128'(6));
    release_res();
    chk("live_hcnt", 128'(hit_count), 128'(4));
    // reset during scan abandons the packet and clears all enables
    phs_data = p3; phs_valid = 1;
    tick();
    phs_valid = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mrst_ready", 128'(phs_ready), 128'(1));
    chk("mrst_valid", 128'(res_valid), 128'(0));
    chk("mrst_hcnt", 128'(hit_count), 128'(0));
    chk("mrst_miss", 128'(miss_count), 128'(0));
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat += int'(res_valid);
    end
    chk("mrst_quiet", 128'(lat), 128'(0));
    send(p3);
    chk("mrst_lat", 128'(lat), 128'(9));
    chk("mrst_hit", 128'(res_hit), 128'(0));
    chk("mrst_idx", 128'(res_idx), 128'(0));
    release_res();
    chk("mrst_miss1", 128'(miss_count), 128'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pdr_rule_matcher.md
Name: pdr_rule_matcher

Overview:
- Sits directly downstream of the N3/N6 packet parser.
- Consumes one PHS_Struct per packet over a valid/ready handshake and scans a small programmable rule table sequentially, one rule per cycle.
- Emits the lowest-index matching rule (the packet-detection result) to the forwarding stage.
- Keeps hit and miss counters for software.

Parameters:
- NUM_RULES, 8, number of rule entries; must be ≥2 and a power of two.
- IDX_W, $clog2(NUM_RULES), rule index width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- phs_valid  in  1  parser result valid.
- phs_ready  out  1  block can accept a PHS.
- phs_data  in  120  PHS_Struct from the parser.
- cfg_we  in  1  rule table write strobe.
- cfg_idx  in  IDX_W  rule entry to write.
- cfg_rule  in  241  PdrRule {en, mask[119:0], value[119:0]}.
- res_valid  out  1  match result valid.
- res_ready  in  1  downstream accepts the result.
- res_hit  out  1  a rule matched.
- res_idx  out  IDX_W  index of the matching rule (0 on miss).
- res_phs  out  120  copy of the PHS that was matched.
- hit_count  out  CNT_W  number of results delivered with hit=1.
- miss_count  out  CNT_W  number of results delivered with hit=0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; res_valid=0, res_hit=0, res_idx=0, res_phs=0.
  - hit_count=0, miss_count=0.
  - Every table entry en=0; mask/value contents are don't-care.
  - Reset mid-scan or mid-DONE abandons the packet; no result is emitted.
- Rule match condition: entry.en && (((phs ^ entry.value) & entry.mask) == 0).
  - mask bit 1 means the bit is compared; mask=0 with en=1 is a wildcard.
- phs_ready = (state==IDLE); it is combinational from state only.
- State machine:
  - IDLE: on phs_valid&&phs_ready, latch phs_data into the PHS register, set scan_idx=0, go to SCAN.
  - SCAN: each cycle, compare table[scan_idx].
    - On a match: set res_hit=1, res_idx=scan_idx, res_valid=1, go to DONE.
    - No match and scan_idx==NUM_RULES-1: set res_hit=0, res_idx=0, res_valid=1, go to DONE.
    - Otherwise: scan_idx+1, stay in SCAN.
  - DONE: hold all res_* outputs stable while res_valid&&!res_ready.
    - On res_ready: res_valid=0, increment hit_count or miss_count, go to IDLE.
- Latency, for a handshake at cycle T:
  - Rule k compared in cycle T+1+k.
  - On a hit at rule k, res_valid rises at T+2+k.
  - On a miss, res_valid rises at T+1+NUM_RULES.
  - Throughput is one packet per (scan length + 1 + downstream wait) cycles; there is no overlap.
- res_phs equals the latched phs_data for the entire DONE period.
- Config writes:
  - Accepted in every state; the write lands at the clk edge.
  - The comparison in the same cycle uses the pre-write contents.
  - A write to an index not yet scanned affects the ongoing scan.
- Counters wrap modulo 2^CNT_W; they do not saturate.
- phs_data and phs_valid are ignored outside IDLE.
- Upstream must hold phs_data stable while phs_valid&&!phs_ready.

Decomposition:
- Add to parser_typedefs_pkg:
  - PdrRule packed struct {logic en; PHS_Struct mask; PHS_Struct value;}.
  - PDR_STATES enum {PDR_IDLE, PDR_SCAN, PDR_DONE}.
- One sub-module, pdr_rule_table:
  - NUM_RULES-entry register array with reset-cleared en bits.
  - Write port (cfg_*) and a combinational read port addressed by scan_idx.
- FSM, PHS register, result register and counters stay in pdr_rule_matcher.

Test Plan:
- Reset with an empty table (all en=0); send PHS ipv4_dst_addr=0x0A000001 -> res_valid at T+9, res_hit=0, res_idx=0, miss_count=1.
- Table rule 3 = {en=1, mask on ipv4_dst_addr only, value 0x0A000001}; send that PHS -> res_valid at T+5, res_hit=1, res_idx=3, res_phs equals input, hit_count=1.
- Rules 2 and 5 both match (rule 5 wildcard mask=0, en=1) -> res_idx=2; disable rule 2 and resend -> res_idx=5.
- Hold res_ready=0 for 10 cycles -> res_* stable, phs_ready=0, counters unchanged; pulse res_ready -> phs_ready=1 the next cycle.
- During a scan, write rule 6 (not yet scanned) to match the latched PHS -> res_idx=6; in the same cycle rule 1 is being compared, write rule 1 to match -> old contents used, no hit on 1.
- Assert rst_n=0 at T+3 mid-scan -> no res_valid, counters 0, all en cleared, phs_ready=1 after reset is released.
